serial_sum_collector: RTL and testbench
=======================================

Name: serial_sum_collector

Overview:
Serial-in, parallel-out collector at the output end of the serial adder datapath. It captures the LSB-first sum bit stream, one bit per valid cycle, and rebuilds a WIDTH-bit word with the final carry. The word is then presented on a valid/ready handshake to downstream parallel logic. It mirrors the parallel-in, serial-out operand shifter on the input side.

Parameters:
WIDTH, 4, number of sum bits per word (legal range 2..32)
CNT_W, $clog2(WIDTH)+1, bit counter width (derived; do not override)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a new word: clear the accumulator and counter
bit_valid  input  1  sum_bit (and carry_bit) are valid this cycle
sum_bit  input  1  serial sum bit, LSB first
carry_bit  input  1  carry register value; sampled only with the final bit
data_out  output  WIDTH  assembled sum word, stable while out_valid=1
carry_out  output  1  final carry of the word
out_valid  output  1  data_out/carry_out hold a completed word
out_ready  input  1  downstream accepts the word
busy  output  1  high in COLLECT
overrun  output  1  sticky: a bit arrived in HOLD and was dropped

Behaviour:
- Reset: one clk, single cycle, synchronous, active-high. rst has priority over every other input.
  - State goes to IDLE.
  - data_out=0, carry_out=0, out_valid=0, busy=0, overrun=0.
  - Internal shift register and counter are cleared to 0.
- State IDLE:
  - bit_valid is ignored.
  - start=1 -> COLLECT. Shift register and count clear to 0; overrun clears.
- State COLLECT (busy=1):
  - Each cycle with bit_valid=1: shreg <= {sum_bit, shreg[WIDTH-1:1]}; count++.
  - Gaps (bit_valid=0) hold all state. There is no timeout.
- Final bit (bit_valid=1 and count==WIDTH-1):
  - data_out <= {sum_bit, shreg[WIDTH-1:1]}.
  - carry_out <= carry_bit.
  - out_valid <= 1, next state HOLD.
  - Latency: out_valid rises on the edge that samples the last bit, so it is visible the following cycle.
- start in COLLECT: aborts the partial word and restarts (count=0, shreg=0). Any bit_valid in that same cycle is discarded.
- State HOLD (out_valid=1):
  - data_out and carry_out are held stable until out_valid && out_ready.
  - Handshake with start=0 -> IDLE, out_valid=0.
  - Handshake with start=1 -> COLLECT directly, cleared, with no bubble.
  - start without out_ready is ignored; the word is never lost.
  - bit_valid=1 sets overrun (sticky) and the bit is dropped.
- overrun clears only on rst or on an accepted start.
- data_out and carry_out keep the last completed word after the handshake; only out_valid qualifies them.
- carry_bit is don't-care except on the final bit.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum {IDLE, COLLECT, HOLD}, 2-bit encoding.
  - Default WIDTH constant, shared with the operand shifter so both ends agree.
- One natural sub-module, sipo_shift_reg:
  - WIDTH-bit right-shifting accumulator plus counter.
  - Ports: clr, shift_en, din; outputs shreg, last (count==WIDTH-1).
- The FSM and output registers stay in the top module.

Test Plan:
- Basic word: rst, then start. Bits 1,1,0,1 on 4 consecutive cycles, carry_bit=1 on the 4th. Required: out_valid=1 the cycle after the 4th bit, data_out=4'hB, carry_out=1. With out_ready=1, out_valid=0 the next cycle.
- Gapped input: bits 0,1,1,0 with bit_valid low for 2 cycles between each bit, carry_bit=0. Required: data_out=4'h6, carry_out=0, busy=1 throughout collection.
- Backpressure plus overrun:
  - Hold out_ready=0 for 5 cycles after completion of 4'hB.
  - Drive bit_valid=1 during HOLD.
  - Required: data_out stays 4'hB, overrun=1.
  - Raise out_ready -> IDLE; overrun stays 1 until the next start.
- Restart mid-word: bits 1,1 then start. Then bits 0,0,1,0. Required: data_out=4'h4, not corrupted by the aborted bits.
- Back-to-back: out_ready and start asserted together in HOLD, then bits 1,0,0,0. Required: second word 4'h1 with no bubble cycle.
- Reset mid-operation: rst after 3 bits, during HOLD, and during a handshake. Required: all outputs 0 the next cycle. No out_valid appears until a fresh start followed by 4 bits.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder datapath: collector FSM states
// and the default word width that both the operand shifter and the collector use.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_shift_reg.sv
// Right-shifting serial-in accumulator with a bit counter; last flags that
// the next shifted bit completes the word.
module sipo_shift_reg #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] shreg,
  output logic             last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shreg <= '0;
      count <= '0;
    end else if (shift_en) begin
      shreg <= {din, shreg[WIDTH-1:1]};
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_sum_collector.sv
// Collects the LSB-first serial sum stream into a WIDTH-bit word plus final
// carry and offers it on a valid/ready handshake.
module serial_sum_collector
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             sum_bit,
  input  logic             carry_bit,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg;
  logic             last;
  logic             clr, shift_en, load, set_ovr, clr_ovr;
  logic             unused_lsb;

  sipo_shift_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .din      (sum_bit),
    .shreg    (shreg),
    .last     (last)
  );

  // The completed word is the shifted value itself, so bit 0 of the
  // pre-shift register never reaches the output.
  assign unused_lsb = shreg[0];

  always_comb begin
    state_next = state;
    clr        = 1'b0;
    shift_en   = 1'b0;
    load       = 1'b0;
    set_ovr    = 1'b0;
    clr_ovr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = COLLECT;
          clr        = 1'b1;
          clr_ovr    = 1'b1;
        end
      end
      COLLECT: begin
        if (start) begin
          clr     = 1'b1;
          clr_ovr = 1'b1;
        end else if (bit_valid) begin
          shift_en = 1'b1;
          if (last) begin
            load       = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        set_ovr = bit_valid;
        if (out_ready) begin
          if (start) begin
            state_next = COLLECT;
            clr        = 1'b1;
            clr_ovr    = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_out  <= '0;
      carry_out <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        data_out  <= {sum_bit, shreg[WIDTH-1:1]};
        carry_out <= carry_bit;
      end
      // A bit dropped in the same cycle as an accepted restart still flags.
      if (set_ovr)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;
    end
  end

  assign out_valid = (state == HOLD);
  assign busy      = (state == COLLECT);

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed bench for serial_sum_collector with hand-computed expected words.
module tb_serial_sum_collector;

  logic       clk = 1'b0;
  logic       rst, start, bit_valid, sum_bit, carry_bit, out_ready;
  logic [3:0] data_out;
  logic       carry_out, out_valid, busy, overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_sum_collector #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .sum_bit   (sum_bit),
    .carry_bit (carry_bit),
    .data_out  (data_out),
    .carry_out (carry_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic c);
    bit_valid = 1'b1;
    sum_bit   = b;
    carry_bit = c;
    tick();
    bit_valid = 1'b0;
    sum_bit   = 1'b0;
    carry_bit = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},   32'(data_out),  32'h0);
    chk({tag, "_carry"},  32'(carry_out), 32'h0);
    chk({tag, "_valid"},  32'(out_valid), 32'h0);
    chk({tag, "_busy"},   32'(busy),      32'h0);
    chk({tag, "_ovr"},    32'(overrun),   32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; sum_bit = 1'b0;
    carry_bit = 1'b0; out_ready = 1'b0;
    tick();
    chk_zero("reset");
    rst = 1'b0;

    // Basic word 1,1,0,1 -> 4'hB, carry 1
    do_start();
    chk("basic_busy", 32'(busy), 32'h1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("basic_not_yet", 32'(out_valid), 32'h0);
    send_bit(1'b1, 1'b1);
    chk("basic_valid", 32'(out_valid), 32'h1);
    chk("basic_data",  32'(data_out),  32'hB);
    chk("basic_carry", 32'(carry_out), 32'h1);
    chk("basic_busy_hold", 32'(busy), 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic_accepted", 32'(out_valid), 32'h0);
    chk("basic_data_kept", 32'(data_out), 32'hB);

    // Gapped word 0,1,1,0 -> 4'h6, carry 0
    do_start();
    for (int i = 0; i < 4; i++) begin
      send_bit((i == 1 || i == 2) ? 1'b1 : 1'b0, 1'b0);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          chk("gap_busy", 32'(busy), 32'h1);
          chk("gap_valid", 32'(out_valid), 32'h0);
        end
      end
    end
    chk("gap_valid_final", 32'(out_valid), 32'h1);
    chk("gap_data",  32'(data_out),  32'h6);
    chk("gap_carry", 32'(carry_out), 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Backpressure with dropped bit and ignored start
    do_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    chk("bp_ovr_before", 32'(overrun), 32'h0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bit_valid = 1'b1;
        sum_bit   = 1'b0;
      end
      if (c == 3) start = 1'b1;
      tick();
      bit_valid = 1'b0;
      start     = 1'b0;
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_data",  32'(data_out),  32'hB);
      chk("bp_carry", 32'(carry_out), 32'h1);
    end
    chk("bp_ovr", 32'(overrun), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_released", 32'(out_valid), 32'h0);
    chk("bp_idle", 32'(busy), 32'h0);
    chk("bp_ovr_sticky", 32'(overrun), 32'h1);
    bit_valid = 1'b1;
    sum_bit   = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("idle_ignore_busy", 32'(busy), 32'h0);
    chk("idle_ignore_ovr", 32'(overrun), 32'h1);
    do_start();
    chk("ovr_cleared", 32'(overrun), 32'h0);

    // Restart mid-word: 1,1 aborted, then 0,0,1,0 -> 4'h4
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    start     = 1'b1;
    bit_valid = 1'b1;
    sum_bit   = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    sum_bit   = 1'b0;
    chk("restart_busy", 32'(busy), 32'h1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("restart_not_yet", 32'(out_valid), 32'h0);
    send_bit(1'b0, 1'b0);
    chk("restart_valid", 32'(out_valid), 32'h1);
    chk("restart_data",  32'(data_out),  32'h4);

    // Back-to-back: accept and restart in one cycle, then 1,0,0,0 -> 4'h1
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("b2b_valid_low", 32'(out_valid), 32'h0);
    chk("b2b_busy", 32'(busy), 32'h1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("b2b_valid", 32'(out_valid), 32'h1);
    chk("b2b_data",  32'(data_out),  32'h1);
    chk("b2b_carry", 32'(carry_out), 32'h1);

    // Reset in HOLD
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_hold");

    // Reset after 3 bits
    do_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("rst_mid");

    // Reset during a handshake
    do_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    chk("pre_rst_data", 32'(data_out), 32'h5);
    out_ready = 1'b1;
    start     = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    chk_zero("rst_hs");

    // Bits without start produce nothing
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    chk("nostart_valid", 32'(out_valid), 32'h0);
    chk("nostart_busy", 32'(busy), 32'h0);

    // Fresh start then 0,1,0,1 -> 4'hA
    do_start();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("fresh_valid", 32'(out_valid), 32'h1);
    chk("fresh_data",  32'(data_out),  32'hA);
    chk("fresh_carry", 32'(carry_out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
